decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pkg.sv | 80 ++++++++
 rtl/mips_instr_dec.sv | 37 +++
 rtl/decode_pipe.sv | 115 +++++++++++
 tb/tb_decode_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared MIPS decode constants, the decoded-field bundle and the opcode/funct
// lookup helpers used by the decoder and the decode_pipe wrapper.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int N_SUP_OPS = 15;
  localparam logic [5:0] SUP_OPS [N_SUP_OPS] = '{
    OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
    OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW
  };

  // Logical immediates take a zero-extended operand.
  localparam int N_ZERO_EXT_OPS = 3;
  localparam logic [5:0] ZERO_EXT_OPS [N_ZERO_EXT_OPS] = '{OP_ANDI, OP_ORI, OP_XORI};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] target;
    logic [31:0] imm;
    logic        is_r;
    logic        is_i;
    logic        is_j;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
  } dec_fields_t;

  function automatic logic is_zero_ext_op(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ZERO_EXT_OPS; i++) hit |= (op == ZERO_EXT_OPS[i]);
    return hit;
  endfunction

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] funct);
    logic op_ok;
    logic fn_ok;
    op_ok = 1'b0;
    for (int i = 0; i < N_SUP_OPS; i++) op_ok |= (op == SUP_OPS[i]);
    fn_ok = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA) ||
            (funct == FN_JR)  || ((funct >= FN_ADD) && (funct <= FN_NOR)) ||
            (funct == FN_SLT) || (funct == FN_SLTU);
    return op_ok && ((op != OP_RTYPE) || fn_ok);
  endfunction

endpackage

// File: rtl/mips_instr_dec.sv
// Combinational MIPS field extraction, immediate extension and class decode.
// All outputs are forced to zero when valid is low.
module mips_instr_dec
  import decode_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] instr,
  output dec_fields_t dec
);

  logic [5:0] op;
  assign op = instr[31:26];

  // NOTE: every field gets a default before the conditional; a path that
  // leaves a combinational output unassigned infers a latch.
  always_comb begin
    dec = '0;
    if (valid) begin
      dec.op        = op;
      dec.rs        = instr[25:21];
      dec.rt        = instr[20:16];
      dec.rd        = instr[15:11];
      dec.shamt     = instr[10:6];
      dec.funct     = instr[5:0];
      dec.target    = instr[25:0];
      dec.imm       = is_zero_ext_op(op) ? {16'h0000, instr[15:0]}
                                         : {{16{instr[15]}}, instr[15:0]};
      dec.is_r      = (op == OP_RTYPE);
      dec.is_j      = (op == OP_J) || (op == OP_JAL);
      dec.is_i      = !dec.is_r && !dec.is_j;
      dec.is_branch = (op == OP_BEQ) || (op == OP_BNE);
      dec.is_load   = (op == OP_LW);
      dec.is_store  = (op == OP_SW);
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Instruction buffer (DEPTH-entry circular FIFO) presenting the decoded head.
// Defining DECODE_PIPE_ILLEGAL_CHK_EN adds the illegal_o unsupported-head flag.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  instr_i,
  input  logic [31:0]                  pc_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  pc_o,
  output logic [5:0]                   op_o,
  output logic [4:0]                   rs_o,
  output logic [4:0]                   rt_o,
  output logic [4:0]                   rd_o,
  output logic [4:0]                   shamt_o,
  output logic [5:0]                   funct_o,
  output logic [25:0]                  target_o,
  output logic [31:0]                  imm_o,
  output logic                         is_r_o,
  output logic                         is_i_o,
  output logic                         is_j_o,
  output logic                         is_branch_o,
  output logic                         is_load_o,
  output logic                         is_store_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
  ,
  output logic                         illegal_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  entry_t           head;
  dec_fields_t      dec;

  // Readiness depends only on occupancy, so a full buffer never passes through.
  assign in_ready_o  = (count < FULL);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // count says they were written, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
  end

  assign head = mem[rd_ptr];

  mips_instr_dec u_dec (
    .valid (out_valid_o),
    .instr (head.instr),
    .dec   (dec)
  );

  assign pc_o        = out_valid_o ? head.pc : '0;
  assign op_o        = dec.op;
  assign rs_o        = dec.rs;
  assign rt_o        = dec.rt;
  assign rd_o        = dec.rd;
  assign shamt_o     = dec.shamt;
  assign funct_o     = dec.funct;
  assign target_o    = dec.target;
  assign imm_o       = dec.imm;
  assign is_r_o      = dec.is_r;
  assign is_i_o      = dec.is_i;
  assign is_j_o      = dec.is_j;
  assign is_branch_o = dec.is_branch;
  assign is_load_o   = dec.is_load;
  assign is_store_o  = dec.is_store;

`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
  assign illegal_o = out_valid_o && !is_supported(head.instr[31:26], head.instr[5:0]);
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: a queue models the FIFO, the head is
// decoded by an independent reference and compared every cycle.
module tb_decode_pipe;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [5:0]  op_o;
  logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
  logic [5:0]  funct_o;
  logic [25:0] target_o;
  logic [31:0] imm_o;
  logic        is_r_o, is_i_o, is_j_o, is_branch_o, is_load_o, is_store_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
  logic        illegal_o;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t q[$];

  decode_pipe #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pc_o        (pc_o),
    .op_o        (op_o),
    .rs_o        (rs_o),
    .rt_o        (rt_o),
    .rd_o        (rd_o),
    .shamt_o     (shamt_o),
    .funct_o     (funct_o),
    .target_o    (target_o),
    .imm_o       (imm_o),
    .is_r_o      (is_r_o),
    .is_i_o      (is_i_o),
    .is_j_o      (is_j_o),
    .is_branch_o (is_branch_o),
    .is_load_o   (is_load_o),
    .is_store_o  (is_store_o),
    .count_o     (count_o)
`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
    ,
    .illegal_o   (illegal_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, ins[15:0]};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  // {is_r, is_i, is_j, is_branch, is_load, is_store}
  function automatic logic [5:0] ref_cls(input logic [31:0] ins);
    logic [5:0] op;
    logic r, j;
    op = ins[31:26];
    r  = (op == 6'h00);
    j  = (op == 6'h02) || (op == 6'h03);
    return {r, !r && !j, j, (op == 6'h04) || (op == 6'h05), op == 6'h23, op == 6'h2B};
  endfunction

`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: case (fn)
               6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b0;
               default: return 1'b1;
             endcase
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction
`endif

  function automatic logic [5:0] cls_out();
    return {is_r_o, is_i_o, is_j_o, is_branch_o, is_load_o, is_store_o};
  endfunction

  task automatic check_state();
    int n;
    n = q.size();
    check("count", 32'(count_o), n);
    check("in_ready", 32'(in_ready_o), 32'(n < DEPTH));
    check("out_valid", 32'(out_valid_o), 32'(n != 0));
    if (n != 0) begin
      check("pc", pc_o, q[0].pc);
      check("fields", {op_o, rs_o, rt_o, rd_o, shamt_o, funct_o}, q[0].instr);
      check("target", {6'b0, target_o}, {6'b0, q[0].instr[25:0]});
      check("imm", imm_o, ref_imm(q[0].instr));
      check("class", 32'(cls_out()), 32'(ref_cls(q[0].instr)));
`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
      check("illegal", 32'(illegal_o), 32'(ref_illegal(q[0].instr)));
`endif
    end else begin
      check("zero_pc_imm", pc_o | imm_o, 32'h0);
      check("zero_fields", {op_o, rs_o, rt_o, rd_o, shamt_o, funct_o}, 32'h0);
      check("zero_tgt_cls", {target_o, cls_out()}, 32'h0);
`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
      check("zero_illegal", 32'(illegal_o), 32'h0);
`endif
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge happen, update the
  // model, then check at the following negedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic do_push, do_pop;
    ent_t e;
    in_valid_i  = v;
    instr_i     = ins;
    pc_i        = pc;
    out_ready_i = rdy;
    flush_i     = fl;
    do_push = v && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() != 0);
    if (do_pop) begin
      check("pop_pc", pc_o, q[0].pc);
      check("pop_instr", {op_o, rs_o, rt_o, rd_o, shamt_o, funct_o}, q[0].instr);
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop) e = q.pop_front();
      if (do_push) q.push_back('{pc: pc, instr: ins});
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [5:0] op_tbl [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h3F};

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    // Reset state, checked while reset is still asserted.
    #1;
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_in_ready", 32'(in_ready_o), 32'h1);
    check("rst_out_valid", 32'(out_valid_o), 32'h0);
    check("rst_imm_pc", imm_o | pc_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_state();

    // lw into an empty buffer: visible after exactly one edge.
    cycle(1'b1, 32'h8C430004, 32'h400, 1'b0, 1'b0);
    check("lw_valid", 32'(out_valid_o), 32'h1);
    check("lw_is_load", 32'(is_load_o), 32'h1);
    check("lw_rs", 32'(rs_o), 32'd2);
    check("lw_rt", 32'(rt_o), 32'd3);
    check("lw_imm", imm_o, 32'h00000004);
    check("lw_pc", pc_o, 32'h400);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // ori zero-extends, addi sign-extends.
    cycle(1'b1, 32'h3442FFFF, 32'h404, 1'b0, 1'b0);
    check("ori_imm", imm_o, 32'h0000FFFF);
    cycle(1'b1, 32'h2042FFFF, 32'h408, 1'b1, 1'b0);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: third instruction held, no pass-through on a full pop.
    cycle(1'b1, 32'h00851020, 32'h500, 1'b0, 1'b0);
    cycle(1'b1, 32'h10A6FFFC, 32'h504, 1'b0, 1'b0);
    cycle(1'b1, 32'hAC870008, 32'h508, 1'b0, 1'b0);
    check("full_count", 32'(count_o), 32'd2);
    check("full_in_ready", 32'(in_ready_o), 32'h0);
    cycle(1'b1, 32'hAC870008, 32'h508, 1'b1, 1'b0);
    check("after_pop_in_ready", 32'(in_ready_o), 32'h1);
    check("after_pop_pc", pc_o, 32'h504);
    cycle(1'b1, 32'hAC870008, 32'h508, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming push+pop with one entry in flight; pointers wrap.
    cycle(1'b1, 32'h08000100, 32'h600, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 32'h24420000 | i, 32'h600 + 4 * i, 1'b1, 1'b0);
      check("stream_count", 32'(count_o), 32'd1);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush overrides a simultaneous push, at count 2 and at count 1.
    cycle(1'b1, 32'h0C000040, 32'h700, 1'b0, 1'b0);
    cycle(1'b1, 32'h1422FFF0, 32'h704, 1'b0, 1'b0);
    cycle(1'b1, 32'h8C010000, 32'h708, 1'b0, 1'b1);
    check("flush_count", 32'(count_o), 32'h0);
    check("flush_valid", 32'(out_valid_o), 32'h0);
    cycle(1'b1, 32'h8C010000, 32'h70C, 1'b0, 1'b0);
    cycle(1'b1, 32'h8C020000, 32'h710, 1'b1, 1'b1);
    check("flush1_count", 32'(count_o), 32'h0);
    idle();

`ifdef DECODE_PIPE_ILLEGAL_CHK_EN
    cycle(1'b1, 32'hFC000000, 32'h800, 1'b0, 1'b0);
    check("illegal_fc", 32'(illegal_o), 32'h1);
    cycle(1'b1, 32'h00000021, 32'h804, 1'b1, 1'b0);
    check("illegal_addu", 32'(illegal_o), 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 120; i++) begin
      r   = $urandom();
      ins = {op_tbl[$urandom_range(0, 9)], r[25:0]};
      cycle($urandom_range(0, 3) != 0, ins, 32'h1000 + 4 * i,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    // Reset in the middle of operation: entries discarded at once.
    cycle(1'b1, 32'h8C430004, 32'h900, 1'b0, 1'b0);
    cycle(1'b1, 32'hAC430004, 32'h904, 1'b0, 1'b0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    rst_n       = 1'b0;
    #1;
    check("midrst_count", 32'(count_o), 32'h0);
    check("midrst_valid", 32'(out_valid_o), 32'h0);
    check("midrst_in_ready", 32'(in_ready_o), 32'h1);
    check("midrst_imm_pc", imm_o | pc_o, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_state();
    cycle(1'b1, 32'h3C01ABCD, 32'hA00, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
